// File: rtl/pulse_stretcher_if.sv
// Event/status bundle between event sources and the pulse stretcher.
// The master side drives strobes; the slave side (the stretcher) drives status.
interface pulse_stretcher_if #(
  parameter int PW = 2
);
  logic          i_in_pulse;
  logic          i_clr_ovf;
  logic          o_out_level;
  logic          o_busy;
  logic [PW-1:0] o_pending;
  logic          o_overflow;

  modport master (
    output i_in_pulse, i_clr_ovf,
    input  o_out_level, o_busy, o_pending, o_overflow
  );

  modport slave (
    input  i_in_pulse, i_clr_ovf,
    output o_out_level, o_busy, o_pending, o_overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events to WIDTH-cycle levels with a GAP-cycle low gap,
// queueing overlapping events in a saturating counter. Optional macro:
// PULSE_STRETCH_RETRIGGER_EN (an event during HIGH extends the pulse instead of queueing).
module pulse_stretcher #(
  parameter int WIDTH = 4,
  parameter int GAP   = 2,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  pulse_stretcher_if.slave bus
);

  localparam int            CMAX     = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int            CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_W    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_G    = CW'(GAP - 1);
  localparam logic [PW-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] r_pending;
  logic [PW-1:0] w_pending_nxt;
  logic          r_overflow;
  logic          w_overflow_nxt;
  logic          r_out_level;
  logic          r_busy;
  logic          w_enq;
  logic          w_deq;
  logic          w_drop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_enq       = 1'b0;
    w_deq       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.i_in_pulse) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_W;
        end
      end

      S_HIGH: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_G;
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (bus.i_in_pulse) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_W;
        end
`else
        w_enq = bus.i_in_pulse;
`endif
      end

      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_enq     = bus.i_in_pulse;
        end else if (r_pending != '0) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_W;
          w_deq       = 1'b1;
        end else if (bus.i_in_pulse) begin
          // A fresh event on the last gap cycle is served directly, bypassing the queue.
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = CNT_W;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Leaving GAP frees a slot in the same cycle, so a coincident event is never dropped.
  always_comb begin
    w_drop        = w_enq && (r_pending == PEND_MAX);
    w_pending_nxt = r_pending;
    if (w_deq) begin
      w_pending_nxt = bus.i_in_pulse ? r_pending : (r_pending - 1'b1);
    end else if (w_enq && !w_drop) begin
      w_pending_nxt = r_pending + 1'b1;
    end

    w_overflow_nxt = r_overflow;
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (bus.i_clr_ovf) begin
      w_overflow_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
      r_out_level <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pending   <= w_pending_nxt;
      r_overflow  <= w_overflow_nxt;
      // Outputs are flops mirroring the next state, so they never glitch on decode.
      r_out_level <= (w_state_nxt == S_HIGH);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.o_out_level = r_out_level;
  assign bus.o_busy      = r_busy;
  assign bus.o_pending   = r_pending;
  assign bus.o_overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (WIDTH=4, GAP=2, PW=2); cycle N of a scenario is
// the N-th clock period after reset release, outputs sampled at its falling edge.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       h_lvl  [0:63];
  logic       h_busy [0:63];
  logic [1:0] h_pend [0:63];
  logic       h_ovf  [0:63];

  pulse_stretcher_if #(.PW(2)) bus ();

  pulse_stretcher #(.WIDTH(4), .GAP(2), .PW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    bus.i_in_pulse = 1'b0;
    bus.i_clr_ovf  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
  endtask

  // Drives one scenario cycle by cycle and records outputs; comparisons live in the tests.
  task automatic run_cycles(input logic [63:0] pul, input logic [63:0] clr,
                            input logic [63:0] rstm, input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      bus.i_in_pulse = pul[c];
      bus.i_clr_ovf  = clr[c];
      rst            = rstm[c];
      @(negedge clk);
      h_lvl[c]  = bus.o_out_level;
      h_busy[c] = bus.o_busy;
      h_pend[c] = bus.o_pending;
      h_ovf[c]  = bus.o_overflow;
      @(posedge clk);
    end
    #1;
    bus.i_in_pulse = 1'b0;
    bus.i_clr_ovf  = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_in_pulse = 1'b1;
    bus.i_clr_ovf  = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_out_level !== 1'b0) begin errors++; $display("FAIL reset_lvl got %b exp 0", bus.o_out_level); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
    checks++; if (bus.o_pending !== 2'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", bus.o_pending); end
    checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.o_overflow); end
    bus.i_in_pulse = 1'b0;
  endtask

  task automatic test_single();
    logic [63:0] el, eb;
    do_reset();
    el = span(11, 14);
    eb = span(11, 16);
    run_cycles(span(10, 10), '0, '0, 25);
    for (int c = 0; c < 25; c++) begin
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL single_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL single_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== 2'd0) begin errors++; $display("FAIL single_pend cyc %0d got %0d exp 0", c, h_pend[c]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] el, eb;
    logic [1:0]  ep;
    do_reset();
    el = span(11, 14) | span(17, 20) | span(23, 26);
    eb = span(11, 28);
    run_cycles(span(10, 12), '0, '0, 32);
    for (int c = 0; c < 32; c++) begin
      ep = (c == 12) ? 2'd1 : (c >= 13 && c <= 16) ? 2'd2 : (c >= 17 && c <= 22) ? 2'd1 : 2'd0;
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL b2b_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== ep) begin errors++; $display("FAIL b2b_pend cyc %0d got %0d exp %0d", c, h_pend[c], ep); end
      checks++; if (h_ovf[c] !== 1'b0) begin errors++; $display("FAIL b2b_ovf cyc %0d got %b exp 0", c, h_ovf[c]); end
    end
  endtask

  // Events 10..13 are served/queued, 14, 15 and 17 are dropped, and 16 is admitted on
  // GAP exit (slot freed that cycle), giving five pulses. clr_ovf at 15 collides with
  // the drop at 15 (set wins); clr_ovf at 30 clears the flag at 31.
  task automatic test_overflow();
    logic [63:0] el, eb, eo;
    logic [1:0]  ep;
    int          rises;
    do_reset();
    el = span(11, 14) | span(17, 20) | span(23, 26) | span(29, 32) | span(35, 38);
    eb = span(11, 40);
    eo = span(15, 30);
    run_cycles(span(10, 17), span(15, 15) | span(30, 30), '0, 45);
    rises = 0;
    for (int c = 0; c < 45; c++) begin
      ep = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c >= 14 && c <= 22) ? 2'd3 :
           (c >= 23 && c <= 28) ? 2'd2 : (c >= 29 && c <= 34) ? 2'd1 : 2'd0;
      if (c > 0 && h_lvl[c] === 1'b1 && h_lvl[c-1] === 1'b0) rises++;
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL ovf_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL ovf_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== ep) begin errors++; $display("FAIL ovf_pend cyc %0d got %0d exp %0d", c, h_pend[c], ep); end
      checks++; if (h_ovf[c] !== eo[c]) begin errors++; $display("FAIL ovf_flag cyc %0d got %b exp %b", c, h_ovf[c], eo[c]); end
    end
    checks++; if (rises !== 5) begin errors++; $display("FAIL ovf_pulse_count got %0d exp 5", rises); end
  endtask

  task automatic test_gap_edge();
    logic [63:0] el, eb;
    do_reset();
    el = span(11, 14) | span(17, 20);
    eb = span(11, 22);
    run_cycles(span(10, 10) | span(16, 16), '0, '0, 26);
    for (int c = 0; c < 26; c++) begin
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL gapedge_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL gapedge_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== 2'd0) begin errors++; $display("FAIL gapedge_pend cyc %0d got %0d exp 0", c, h_pend[c]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] el, eb;
    logic [1:0]  ep;
    do_reset();
    el = span(11, 12) | span(31, 34);
    eb = span(11, 12) | span(31, 36);
    run_cycles(span(10, 12) | span(30, 30), '0, span(13, 13), 40);
    for (int c = 0; c < 40; c++) begin
      ep = (c == 12) ? 2'd1 : 2'd0;
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL midrst_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL midrst_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== ep) begin errors++; $display("FAIL midrst_pend cyc %0d got %0d exp %0d", c, h_pend[c], ep); end
    end
  endtask

  task automatic test_retrigger();
    logic [63:0] el, eb;
    logic [1:0]  ep;
    do_reset();
`ifdef PULSE_STRETCH_RETRIGGER_EN
    el = span(11, 16);
    eb = span(11, 18);
`else
    el = span(11, 14) | span(17, 20);
    eb = span(11, 22);
`endif
    run_cycles(span(10, 10) | span(12, 12), '0, '0, 26);
    for (int c = 0; c < 26; c++) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      ep = 2'd0;
`else
      ep = (c >= 13 && c <= 16) ? 2'd1 : 2'd0;
`endif
      checks++; if (h_lvl[c] !== el[c]) begin errors++; $display("FAIL retrig_lvl cyc %0d got %b exp %b", c, h_lvl[c], el[c]); end
      checks++; if (h_busy[c] !== eb[c]) begin errors++; $display("FAIL retrig_busy cyc %0d got %b exp %b", c, h_busy[c], eb[c]); end
      checks++; if (h_pend[c] !== ep) begin errors++; $display("FAIL retrig_pend cyc %0d got %0d exp %0d", c, h_pend[c], ep); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_edge();
    test_mid_reset();
    test_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
